// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks destination registers of in-flight instructions
// (EX, MEM, WB), generates registered forwarding selects for the instruction
// entering EX, raises the load-use stall for the instruction in ID, and
// counts stall cycles with a saturating counter.
module hazard_scoreboard #(
  parameter int unsigned REGW = 5,
  parameter int unsigned CNTW = 16
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            IdValid,
  input  logic [REGW-1:0] IdRs1,
  input  logic [REGW-1:0] IdRs2,
  input  logic            IdRs1Used,
  input  logic            IdRs2Used,
  input  logic [REGW-1:0] IdRd,
  input  logic            IdRegWrite,
  input  logic            IdMemRead,
  input  logic            Flush,
  input  logic            Hold,
  output logic            Stall,
  output logic [1:0]      ForwardA,
  output logic [1:0]      ForwardB,
  output logic [CNTW-1:0] StallCount
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FROZEN  = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  state_t          r_state;
  state_t          r_prior;

  logic            r_ex_v,  r_ex_rw,  r_ex_mr;
  logic [REGW-1:0] r_ex_rd;
  logic            r_mem_v, r_mem_rw, r_mem_mr;
  logic [REGW-1:0] r_mem_rd;
  logic            r_wb_v,  r_wb_rw,  r_wb_mr;
  logic [REGW-1:0] r_wb_rd;

  logic [1:0]      r_fwd_a;
  logic [1:0]      r_fwd_b;
  logic [CNTW-1:0] r_cnt;

  logic            w_ex_wr_rs1, w_ex_wr_rs2;
  logic            w_mem_wr_rs1, w_mem_wr_rs2;
  logic            w_load_use;
  logic            w_stall;
  logic [1:0]      w_fwd_a_nxt;
  logic [1:0]      w_fwd_b_nxt;
  logic            w_unused;

  // Slot-match terms, load-use detection and next forwarding selects
  always_comb begin
    w_ex_wr_rs1  = r_ex_v  && r_ex_rw  && (r_ex_rd  == IdRs1) && (IdRs1 != '0);
    w_ex_wr_rs2  = r_ex_v  && r_ex_rw  && (r_ex_rd  == IdRs2) && (IdRs2 != '0);
    w_mem_wr_rs1 = r_mem_v && r_mem_rw && (r_mem_rd == IdRs1) && (IdRs1 != '0);
    w_mem_wr_rs2 = r_mem_v && r_mem_rw && (r_mem_rd == IdRs2) && (IdRs2 != '0);

    w_load_use = IdValid && r_ex_mr &&
                 ((IdRs1Used && w_ex_wr_rs1) || (IdRs2Used && w_ex_wr_rs2));
    w_stall    = w_load_use && !Flush;

    w_fwd_a_nxt = FWD_RF;
    if (IdValid && IdRs1Used) begin
      if (w_ex_wr_rs1)       w_fwd_a_nxt = FWD_EXM;
      else if (w_mem_wr_rs1) w_fwd_a_nxt = FWD_MWB;
    end

    w_fwd_b_nxt = FWD_RF;
    if (IdValid && IdRs2Used) begin
      if (w_ex_wr_rs2)       w_fwd_b_nxt = FWD_EXM;
      else if (w_mem_wr_rs2) w_fwd_b_nxt = FWD_MWB;
    end
  end

  // Tracker shift, forwarding select registers, stall counter and control state
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= RUN;
      r_prior  <= RUN;
      r_ex_v   <= 1'b0; r_ex_rd  <= '0; r_ex_rw  <= 1'b0; r_ex_mr  <= 1'b0;
      r_mem_v  <= 1'b0; r_mem_rd <= '0; r_mem_rw <= 1'b0; r_mem_mr <= 1'b0;
      r_wb_v   <= 1'b0; r_wb_rd  <= '0; r_wb_rw  <= 1'b0; r_wb_mr  <= 1'b0;
      r_fwd_a  <= FWD_RF;
      r_fwd_b  <= FWD_RF;
      r_cnt    <= '0;
    end else if (Hold) begin
      // Frozen: everything keeps its value; remember where to resume.
      if (r_state != FROZEN) r_prior <= r_state;
      r_state <= FROZEN;
    end else begin
      r_wb_v  <= r_mem_v;  r_wb_rd  <= r_mem_rd;  r_wb_rw  <= r_mem_rw;  r_wb_mr  <= r_mem_mr;
      r_mem_v <= r_ex_v;   r_mem_rd <= r_ex_rd;   r_mem_rw <= r_ex_rw;   r_mem_mr <= r_ex_mr;
      if (Flush || w_stall) begin
        r_ex_v  <= 1'b0;
        r_ex_rd <= '0;
        r_ex_rw <= 1'b0;
        r_ex_mr <= 1'b0;
        r_fwd_a <= FWD_RF;
        r_fwd_b <= FWD_RF;
        if (w_stall && (r_cnt != '1)) r_cnt <= r_cnt + CNTW'(1);
      end else begin
        r_ex_v  <= IdValid;
        r_ex_rd <= IdRd;
        r_ex_rw <= IdRegWrite;
        r_ex_mr <= IdMemRead;
        r_fwd_a <= w_fwd_a_nxt;
        r_fwd_b <= w_fwd_b_nxt;
      end
      r_state <= w_stall ? LDSTALL : RUN;
    end
  end

  // WB slot and saved state are architectural bookkeeping with no consumer here
  assign w_unused = ^{r_wb_v, r_wb_rd, r_wb_rw, r_wb_mr, r_prior};

  assign Stall      = w_stall;
  assign ForwardA   = r_fwd_a;
  assign ForwardB   = r_fwd_b;
  assign StallCount = r_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (CNTW reduced to 3 so
// saturation is reachable quickly).
module tb_hazard_scoreboard;

  localparam int unsigned REGW = 5;
  localparam int unsigned CNTW = 3;

  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic [REGW-1:0] id_rs1, id_rs2, id_rd;
  logic            id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
  logic            flush, hold;
  logic            stall;
  logic [1:0]      fwd_a, fwd_b;
  logic [CNTW-1:0] stall_count;

  int unsigned n_checks;
  int unsigned n_errors;

  hazard_scoreboard #(.REGW(REGW), .CNTW(CNTW)) u_dut (
    .Clk        (clk),
    .Rst_n      (rst_n),
    .IdValid    (id_valid),
    .IdRs1      (id_rs1),
    .IdRs2      (id_rs2),
    .IdRs1Used  (id_rs1_used),
    .IdRs2Used  (id_rs2_used),
    .IdRd       (id_rd),
    .IdRegWrite (id_reg_write),
    .IdMemRead  (id_mem_read),
    .Flush      (flush),
    .Hold       (hold),
    .Stall      (stall),
    .ForwardA   (fwd_a),
    .ForwardB   (fwd_b),
    .StallCount (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge, land 1ns after it
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [REGW-1:0] rs1, input logic u1,
                        input logic [REGW-1:0] rs2, input logic u2,
                        input logic [REGW-1:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    #1;
  endtask

  task automatic id_nop();
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic nops(input int unsigned n);
    id_nop();
    for (int unsigned i = 0; i < n; i++) edge1();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
    id_nop();
    #2;
    check("rst_stall", stall, 0);
    check("rst_fa", fwd_a, 0);
    check("rst_fb", fwd_b, 0);
    check("rst_cnt", stall_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    edge1();

    // ALU chain: I1 writes x5, I2 reads x5 on rs1
    id_set(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    edge1();
    id_set(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
    check("alu_stall", stall, 0);
    edge1();
    id_nop();
    check("alu_fa", fwd_a, 1);
    check("alu_fb", fwd_b, 0);
    nops(3);

    // Distance-2: x7 producer, bubble, consumer on rs2
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    edge1();
    id_nop();
    edge1();
    id_set(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    edge1();
    id_nop();
    check("d2_fb", fwd_b, 2);
    nops(3);

    // Distance-2 with a younger x7 producer in between
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    edge1();
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    edge1();
    id_set(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    edge1();
    id_nop();
    check("d2y_fb", fwd_b, 1);
    nops(3);

    // Load-use: LW x9, ADD x9,x9
    id_set(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    edge1();
    id_set(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0);
    check("lu_stall1", stall, 1);
    check("lu_cnt0", stall_count, 0);
    edge1();
    check("lu_stall2", stall, 0);
    check("lu_cnt1", stall_count, 1);
    edge1();
    id_nop();
    check("lu_fa", fwd_a, 2);
    check("lu_fb", fwd_b, 2);
    nops(3);

    // x0: producer load writes x0, consumer reads x0
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    edge1();
    id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    check("x0_stall", stall, 0);
    edge1();
    id_nop();
    check("x0_fa", fwd_a, 0);
    check("x0_fb", fwd_b, 0);
    nops(3);

    // Unused rs2 that matches the producer
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    edge1();
    id_set(1'b1, 5'd1, 1'b1, 5'd12, 1'b0, 5'd13, 1'b1, 1'b0);
    edge1();
    id_nop();
    check("unused_fb", fwd_b, 0);
    check("unused_fa", fwd_a, 0);
    nops(3);

    // Hold for three cycles during a load-use condition
    id_set(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    edge1();
    id_set(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    hold = 1'b1;
    #1;
    check("hold_stall0", stall, 1);
    for (int unsigned i = 0; i < 3; i++) begin
      edge1();
      check("hold_stall", stall, 1);
      check("hold_cnt", stall_count, 1);
    end
    hold = 1'b0;
    edge1();
    check("hold_rel_cnt", stall_count, 2);
    check("hold_rel_stall", stall, 0);
    edge1();
    id_nop();
    check("hold_fa", fwd_a, 2);
    nops(3);

    // Flush together with load-use
    id_set(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    edge1();
    id_set(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_stall", stall, 0);
    edge1();
    flush = 1'b0;
    #1;
    check("flush_cnt", stall_count, 2);
    check("flush_fa_bubble", fwd_a, 0);
    check("flush_ex_bubble", stall, 0);
    edge1();
    id_nop();
    check("flush_mem_fa", fwd_a, 2);
    nops(3);

    // Reset in the middle of a stall cycle
    id_set(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    edge1();
    id_set(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    check("mrst_pre", stall, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_stall", stall, 0);
    rst_n = 1'b1;
    #1;
    check("mrst_fa", fwd_a, 0);
    check("mrst_fb", fwd_b, 0);
    check("mrst_cnt", stall_count, 0);
    edge1();
    check("mrst_stall_after", stall, 0);
    nops(3);

    // Saturation: eight load-use stalls on a 3-bit counter stop at 7
    for (int unsigned k = 0; k < 8; k++) begin
      id_set(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
      edge1();
      id_set(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0);
      edge1();
      edge1();
      id_nop();
    end
    check("sat_cnt", stall_count, 7);
    nops(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Tracks the destination registers of in-flight instructions through the EX, MEM and WB stages.
- Produces the registered forwarding selects for the instruction entering EX.
- Raises the load-use stall for the instruction in ID.
- Counts stall cycles for performance monitoring.
- Sits beside the ID/EX pipeline register on the producer side of forwarding: it generates the pipeline-state decisions that the EX-stage forwarding muxes consume.

## Interface
Parameters:
- REGW, default 5: register index width.
- CNTW, default 16: stall counter width.

Ports:
- Clk, input, 1: clock, rising edge.
- Rst_n, input, 1: reset, asynchronous, active-low.
- IdValid, input, 1: ID slot holds a real instruction.
- IdRs1, input, REGW: source register 1 of the ID instruction.
- IdRs2, input, REGW: source register 2 of the ID instruction.
- IdRs1Used, input, 1: the ID instruction reads rs1.
- IdRs2Used, input, 1: the ID instruction reads rs2.
- IdRd, input, REGW: destination register of the ID instruction.
- IdRegWrite, input, 1: the ID instruction writes IdRd.
- IdMemRead, input, 1: the ID instruction is a load.
- Flush, input, 1: taken branch resolved; kill the ID instruction.
- Hold, input, 1: data-memory wait; freeze the entire pipeline.
- Stall, output, 1: hold PC and IF/ID, insert a bubble into EX (combinational).
- ForwardA, output, 2: rs1 select for the instruction currently in EX.
- ForwardB, output, 2: rs2 select for the instruction currently in EX.
- StallCount, output, CNTW: saturating count of load-use stall cycles.

Forward encoding:
- 00: register file.
- 01: EX/MEM result.
- 10: MEM/WB result.
- 11: never driven.

## Operation
- Three tracker slots (EX, MEM, WB) each hold {V, Rd, RegWrite, MemRead}.
- A slot "writes r" iff V=1, RegWrite=1, Rd=r and r≠0.
- Load-use condition, evaluated combinationally:
  - IdValid=1;
  - the EX slot has V=1, MemRead=1, RegWrite=1 and Rd≠0;
  - the EX slot's Rd equals IdRs1 with IdRs1Used=1, or IdRs2 with IdRs2Used=1.
- Stall = load-use condition AND NOT Flush. Stall is independent of Hold.
- Forward computation for source s (rs1 or rs2), based on the instruction in ID:
  - If s is used and the EX slot writes s: next select = 01. The EX producer will be in MEM when the consumer is in EX.
  - Else if s is used and the MEM slot writes s: next select = 10.
  - Else: next select = 00.
  - Priority: the youngest producer (EX slot) always wins.
  - A load in the EX slot never yields 01, because Stall prevents the advance.
- Per-edge update, first matching rule applies:
  1. Hold=1: all trackers, ForwardA/B and StallCount keep their values.
  2. Flush=1: WB←MEM, MEM←EX, EX←bubble (V=0), ForwardA/B←00.
  3. Stall=1: WB←MEM, MEM←EX, EX←bubble, ForwardA/B←00, StallCount+1 (saturating at all-ones).
  4. Otherwise: WB←MEM, MEM←EX, EX←{IdValid, IdRd, IdRegWrite, IdMemRead}, ForwardA/B←computed selects. Selects are 00 when IdValid=0.
- Internal control states:
  - RUN (default).
  - LDSTALL: entered on any Stall edge; returns to RUN when Stall deasserts.
  - FROZEN: held while Hold=1; returns to the prior state.
  - The state is observable only through the rules above.

## Timing
- Stall: zero latency, combinational from the ID inputs and EX-slot state.
- ForwardA/B: registered, valid the whole cycle the consumer occupies EX, i.e. one edge after it leaves ID.
- A load-use hazard costs exactly one stall cycle. On the next edge the load is in MEM; when the consumer advances, it receives 10.
- Reset (asynchronous, any time, including mid-stall or mid-Hold):
  - all V←0, Rd←0, ForwardA/B←00, StallCount←0, state←RUN;
  - Stall=0 immediately, since the EX slot is invalid.
- Simultaneous Flush and load-use: Flush wins; no stall, no count.
- Simultaneous Hold and Flush: Hold wins. Flush must be re-presented after Hold drops.
- At StallCount = all-ones, further stalls leave it unchanged.

## Test plan
- ALU chain: I1 writes x5; next cycle I2 reads rs1=x5. When I2 is in EX: ForwardA=01, ForwardB=00, Stall never asserted.
- Distance-2 with override:
  - I1 writes x7, then a NOP, then I3 reads rs2=x7: ForwardB=10.
  - Repeat with the middle instruction also writing x7: ForwardB=01 (younger wins).
- Load-use:
  - LW x9, then ADD reading x9 on both sources: Stall=1 for exactly one cycle, StallCount 0→1.
  - When ADD is in EX: ForwardA=ForwardB=10.
- x0 and unused sources:
  - Producer writes x0 and consumer reads x0: selects 00, no stall.
  - Consumer with IdRs2Used=0 but IdRs2 matching: ForwardB=00.
- Hold/Flush:
  - Hold=1 for 3 cycles during a load-use condition: Stall stays 1 and StallCount is unchanged until Hold drops.
  - Flush together with load-use: Stall=0 and the EX slot becomes a bubble.
- Reset mid-stall: drop Rst_n during a Stall cycle. Stall→0 asynchronously; ForwardA/B=00 and StallCount=0 after release.
